vec_skid_pipe: RTL and testbench

- Elastic, parameterised vector delay pipeline with a valid/ready handshake on both sides.
- Sits directly upstream of the team's vector D-flop stage.
- Replaces free-running clocked capture with a flow-controlled path. Upstream producers are back-pressured instead of having beats overwritten.
- Output is a registered, hold-stable vector suitable to drive the vector flop's `in` port.

---
 rtl/vec_skid_pipe_pkg.sv | 23 ++
 rtl/vec_skid_pipe_stage.sv | 47 ++++
 rtl/vec_skid_pipe.sv | 144 ++++++++++++++
 tb/tb_vec_skid_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_skid_pipe_pkg.sv
// -----------------------------------------------------------------------------
// vec_pipe_pkg
// Shared types and helpers for the vec_skid_pipe elastic vector pipeline.
//   occ_width(latency) : width of the occupancy counter (holds 0..latency+1)
//   DEFAULT_SIZE       : default data vector width
//   DEFAULT_LATENCY    : default number of elastic stages
//   skid_state_t       : skid register state
// -----------------------------------------------------------------------------
package vec_pipe_pkg;

   localparam int DEFAULT_SIZE    = 1;
   localparam int DEFAULT_LATENCY = 1;

   typedef enum logic {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_t;

   function automatic int occ_width(input int latency);
      return $clog2(latency + 2);
   endfunction

endpackage

// File: rtl/vec_skid_pipe_stage.sv
// -----------------------------------------------------------------------------
// vec_pipe_stage
// One elastic register stage of the vec_skid_pipe chain.
// Ports:
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   i_prev_valid  : predecessor holds a beat
//   i_prev_data   : predecessor beat
//   i_next_ready  : successor can take this stage's beat
//   o_valid       : this stage holds a beat
//   o_data        : this stage's beat
//   o_ready       : this stage loads from its predecessor on the next edge
// -----------------------------------------------------------------------------
module vec_pipe_stage #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_prev_valid,
   input  logic [WIDTH-1:0] i_prev_data,
   input  logic             i_next_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_ready
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // An empty stage always loads, so bubbles collapse toward the output.
   assign o_ready = !r_valid || i_next_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_prev_valid;
         if (i_prev_valid) begin
            r_data <= i_prev_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/vec_skid_pipe.sv
// -----------------------------------------------------------------------------
// vec_skid_pipe
// Elastic vector delay pipeline: one skid register in front of LATENCY
// elastic stages, valid/ready on both sides, order always preserved.
// Optional feature macro: VEC_SKID_PIPE_PARITY_EN (carry an even-parity bit
// with every beat and flag mismatches at the output on out_perr).
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   in_data     : upstream beat, [0:SIZE-1], bit 0 is MSB
//   in_valid    : upstream beat present
//   in_ready    : block can accept (registered)
//   out_data    : beat to downstream, held while stalled
//   out_valid   : out_data valid
//   out_ready   : downstream accepts
//   occupancy   : beats currently held (0..LATENCY+1)
//   out_perr    : parity error on the presented beat (0 without the feature)
// -----------------------------------------------------------------------------
module vec_skid_pipe
   import vec_pipe_pkg::*;
#(
   parameter int SIZE    = DEFAULT_SIZE,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [0:SIZE-1]               in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [0:SIZE-1]               out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [occ_width(LATENCY)-1:0] occupancy,
   output logic                          out_perr
);

   localparam int OW = occ_width(LATENCY);
`ifdef VEC_SKID_PIPE_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int W = SIZE + PW;

   if (SIZE < 1 || LATENCY < 1) begin : g_cfg_err
      $error("vec_skid_pipe: SIZE and LATENCY must both be >= 1");
   end

   skid_state_t  r_skid;
   logic [W-1:0] r_s_data;
   logic         r_in_ready;
   logic [OW-1:0] r_occ;

   logic         w_push;
   logic         w_pop;
   logic         w_rdy0;
   logic [W-1:0] w_in_word;
   logic         w_v [0:LATENCY];
   logic [W-1:0] w_d [0:LATENCY];

`ifdef VEC_SKID_PIPE_PARITY_EN
   assign w_in_word = {in_data, ^in_data};
   assign out_perr  = w_v[LATENCY] && ((^w_d[LATENCY][W-1:1]) != w_d[LATENCY][0]);
`else
   assign w_in_word = in_data;
   assign out_perr  = 1'b0;
`endif

   assign w_push = in_valid && r_in_ready;
   assign w_pop  = w_v[LATENCY] && out_ready;

   // A full skid register always feeds P0 ahead of new input, so it never
   // gets bypassed; in_ready is low while it is full.
   assign w_v[0] = (r_skid == SKID_FULL) || w_push;
   assign w_d[0] = (r_skid == SKID_FULL) ? r_s_data : w_in_word;

   // Each stage's ready lives in its own generate scope so the ready chain
   // is a set of separate nets rather than one self-referencing array.
   for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      logic w_rdy;
      logic w_next_rdy;

      if (i == LATENCY - 1) begin : g_last
         assign w_next_rdy = out_ready;
      end else begin : g_mid
         assign w_next_rdy = g_stage[i+1].w_rdy;
      end

      vec_pipe_stage #(
         .WIDTH(W)
      ) u_stage (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_prev_valid(w_v[i]),
         .i_prev_data (w_d[i]),
         .i_next_ready(w_next_rdy),
         .o_valid     (w_v[i+1]),
         .o_data      (w_d[i+1]),
         .o_ready     (w_rdy)
      );
   end

   assign w_rdy0 = g_stage[0].w_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid     <= SKID_EMPTY;
         r_s_data   <= '0;
         r_in_ready <= 1'b0;
         r_occ      <= '0;
      end else begin
         unique case (r_skid)
            SKID_EMPTY: begin
               if (w_push && !w_rdy0) begin
                  r_skid     <= SKID_FULL;
                  r_s_data   <= w_in_word;
                  r_in_ready <= 1'b0;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            SKID_FULL: begin
               if (w_rdy0) begin
                  r_skid     <= SKID_EMPTY;
                  r_in_ready <= 1'b1;
               end else begin
                  r_in_ready <= 1'b0;
               end
            end
         endcase

         if (w_push && !w_pop) begin
            r_occ <= r_occ + OW'(1);
         end else if (!w_push && w_pop) begin
            r_occ <= r_occ - OW'(1);
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = w_v[LATENCY];
   assign out_data  = w_d[LATENCY][W-1 -: SIZE];
   assign occupancy = r_occ;

endmodule

// File: tb/tb_vec_skid_pipe.sv
module tb_vec_skid_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // index 0: SIZE=5 LATENCY=3, index 1: SIZE=10 LATENCY=2
   logic        iv   [2];
   logic        ir   [2];
   logic        ov   [2];
   logic        orr  [2];
   logic        perr [2];
   logic [31:0] id   [2];
   logic [31:0] od   [2];
   int unsigned occ_v[2];

   logic [0:4] a_od;
   logic [0:9] b_od;
   logic [2:0] a_occ;
   logic [1:0] b_occ;

   always_comb begin
      od[0]    = 32'(a_od);
      od[1]    = 32'(b_od);
      occ_v[0] = 32'(a_occ);
      occ_v[1] = 32'(b_occ);
   end

   vec_skid_pipe #(.SIZE(5), .LATENCY(3)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(id[0][4:0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .out_data(a_od), .out_valid(ov[0]), .out_ready(orr[0]),
      .occupancy(a_occ), .out_perr(perr[0])
   );

   vec_skid_pipe #(.SIZE(10), .LATENCY(2)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(id[1][9:0]), .in_valid(iv[1]), .in_ready(ir[1]),
      .out_data(b_od), .out_valid(ov[1]), .out_ready(orr[1]),
      .occupancy(b_occ), .out_perr(perr[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          m_occ [2];
   int          pops  [2];
   logic        held  [2];
   logic [31:0] held_d[2];
   logic        par_force[2];

   function automatic int qsz(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   // expected beats enter the scoreboard as the stimulus is accepted
   always @(negedge clk) begin
      if (rst_n) begin
         if (iv[0] && ir[0]) q0.push_back(id[0] & 32'h1F);
         if (iv[1] && ir[1]) q1.push_back(id[1] & 32'h3FF);
      end
   end

   // monitor: compares presented beats, occupancy, hold stability, parity flag
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_occ[k] = 0;
            held[k]  = 1'b0;
         end else begin
            logic [31:0] exp;
            chk("occupancy", occ_v[k], m_occ[k]);
            chk("out_perr", perr[k], (par_force[k] && ov[k]) ? 1 : 0);
            if (held[k]) begin
               chk("hold_valid", ov[k], 1);
               chk("hold_data", od[k], held_d[k]);
            end
            if (ov[k] && orr[k]) begin
               if (qsz(k) == 0) begin
                  chk("unexpected_beat", qsz(k), 1);
               end else begin
                  exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                  if (par_force[k]) exp = exp ^ ((k == 0) ? 32'h10 : 32'h200);
                  chk("out_data", od[k], exp);
                  pops[k]++;
               end
            end
            m_occ[k]  = m_occ[k] + ((iv[k] && ir[k]) ? 1 : 0) - ((ov[k] && orr[k]) ? 1 : 0);
            held[k]   = ov[k] && !orr[k];
            held_d[k] = od[k];
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int k, input logic [31:0] v);
      int   n = 0;
      logic acc;
      id[k] = v;
      iv[k] = 1'b1;
      do begin
         @(negedge clk);
         acc = ir[k];
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 300);
      chk("send_accept", acc, 1);
      iv[k] = 1'b0;
   endtask

   task automatic measure_latency(input int k, input int exp_lat, input string name);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ov[k] && n < 50);
      chk(name, n, exp_lat);
   endtask

   task automatic drain(input int k);
      int n = 0;
      while ((qsz(k) != 0 || ov[k]) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", qsz(k), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   bit rdone;
   int p_start;

   initial begin
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b1; id[k] = '0; orr[k] = 1'b0;
         m_occ[k] = 0; pops[k] = 0; held[k] = 1'b0; held_d[k] = '0; par_force[k] = 1'b0;
      end
      rst_n = 1'b0;

      // reset with in_valid held high
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", ir[k], 0);
         chk("rst_out_valid", ov[k], 0);
         chk("rst_out_data", od[k], 0);
         chk("rst_occupancy", occ_v[k], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("in_ready_after_rst", ir[k], 1);
         iv[k] = 1'b0;
      end

      // streaming 01..0A, SIZE=5 LATENCY=3
      orr[0] = 1'b1;
      fork
         begin
            for (int v = 1; v <= 10; v++) send(0, 32'(v));
         end
         begin
            measure_latency(0, 3, "stream_latency");
            for (int i = 1; i < 10; i++) begin
               @(posedge clk);
               #1;
               chk("stream_no_gap", ov[0], 1);
            end
         end
      join
      drain(0);
      chk("stream_beats", pops[0], 10);

      // back-pressure: capacity LATENCY+1, output held stable
      orr[0] = 1'b0;
      for (int v = 1; v <= 4; v++) send(0, 32'(v));
      chk("bp_in_ready_low", ir[0], 0);
      id[0] = 32'h5;
      iv[0] = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", ir[0], 0);
         chk("bp_occupancy", occ_v[0], 4);
         chk("bp_out_data", od[0], 32'h01);
         chk("bp_out_valid", ov[0], 1);
      end
      orr[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_in_ready_after_pop", ir[0], 1);
      iv[0] = 1'b0;
      drain(0);
      chk("bp_beats", pops[0], 14);

      // random bubbles, SIZE=10 LATENCY=2
      p_start = pops[1];
      rdone   = 1'b0;
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send(1, 32'($urandom_range(0, 1023)));
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               orr[1] = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            orr[1] = 1'b1;
         end
      join
      drain(1);
      chk("rand_beats", pops[1] - p_start, 1000);

      // asynchronous reset with 3 beats held
      orr[1] = 1'b0;
      send(1, 32'h11);
      send(1, 32'h22);
      send(1, 32'h33);
      chk("full_in_ready", ir[1], 0);
      chk("full_occupancy", occ_v[1], 3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", ov[1], 0);
      chk("async_rst_occupancy", occ_v[1], 0);
      chk("async_rst_in_ready", ir[1], 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_rst2", ir[1], 1);
      orr[1] = 1'b1;
      fork
         send(1, 32'h2A);
         measure_latency(1, 2, "post_rst_latency");
      join
      chk("post_rst_data", od[1], 32'h2A);
      @(posedge clk);
      #1;
      chk("post_rst_alone", ov[1], 0);
      drain(1);

`ifdef VEC_SKID_PIPE_PARITY_EN
      // corrupt MSB of beat 5'h03 in the last stage of instance 0
      orr[0] = 1'b0;
      force u_a.g_stage[2].u_stage.r_data = 6'b100110;
      par_force[0] = 1'b1;
      send(0, 32'h03);
      repeat (3) @(posedge clk);
      #1;
      chk("par_flag_on", perr[0], 1);
      orr[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("par_popped", ov[0], 0);
      release u_a.g_stage[2].u_stage.r_data;
      par_force[0] = 1'b0;
      send(0, 32'h04);
      send(0, 32'h05);
      drain(0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
